// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory controller: FSM states,
// request kinds, frame lengths and default opcodes.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_FINISH
    } spi_state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ROM_RD,
        OP_RAM_RD,
        OP_RAM_WR
    } spi_op_t;

    localparam int ROM_BITS = 40;
    localparam int RAM_BITS = 32;

    localparam logic [7:0] DEF_ROM_CMD    = 8'h03;
    localparam logic [7:0] DEF_RAM_RD_CMD = 8'h03;
    localparam logic [7:0] DEF_RAM_WR_CMD = 8'h02;

    // RAM write wins over RAM read, which wins over ROM fetch.
    function automatic spi_op_t decode_op(input logic wr, input logic rd, input logic rom);
        if (wr)  return OP_RAM_WR;
        if (rd)  return OP_RAM_RD;
        if (rom) return OP_ROM_RD;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/spi_mem_ctrl_sck_gen.sv
// SPI mode-0 clock generator: CLK_DIV system clocks per half period, with
// single-cycle rise/fall enables. Held low and cleared whenever en is low.
module spi_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    logic [3:0] cnt;
    logic       last;

    assign last = (cnt == 4'(CLK_DIV - 1));
    assign rise = en && last && !sck;
    assign fall = en && last && sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (last) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI master serving CU memory requests: flash byte fetch, SRAM byte read
// and SRAM byte write, with completion signalled by a rising spi_done.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int         CLK_DIV    = 1,
    parameter logic [7:0] ROM_HI     = 8'h00,
    parameter logic [7:0] ROM_CMD    = DEF_ROM_CMD,
    parameter logic [7:0] RAM_RD_CMD = DEF_RAM_RD_CMD,
    parameter logic [7:0] RAM_WR_CMD = DEF_RAM_WR_CMD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_executing,
    input  logic        op_rom_rd,
    input  logic        op_ram_rd,
    input  logic        op_ram_wr,
    input  logic [15:0] rom_addr,
    input  logic [15:0] ram_addr,
    input  logic [7:0]  wdata,
    output logic        spi_done,
    output logic [7:0]  rdata,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_rom_n,
    output logic        cs_ram_n
);

    spi_state_t  state_q, state_d;
    spi_op_t     op_q, op_d, req_op;
    logic        pend_q, pend_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        cs_rom_n_q, cs_rom_n_d;
    logic        cs_ram_n_q, cs_ram_n_d;
    logic        in_frame;
    logic        rise;
    logic        fall;

    assign in_frame = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_frame),
        .sck   (sck),
        .rise  (rise),
        .fall  (fall)
    );

    // Whole frame is preloaded MSB-aligned at accept; trailing bits are zero
    // so mosi idles low through the read data phase.
    assign mosi     = in_frame && tx_q[39];
    assign spi_done = done_q;
    assign rdata    = rdata_q;
    assign cs_rom_n = cs_rom_n_q;
    assign cs_ram_n = cs_ram_n_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        done_d     = done_q;
        cs_rom_n_d = cs_rom_n_q;
        cs_ram_n_d = cs_ram_n_q;
        req_op     = decode_op(op_ram_wr, op_ram_rd, op_rom_rd);

        case (state_q)
            ST_IDLE: begin
                // pend splits accept from frame start, so the CU sees done drop
                // one cycle after the accept edge even for a no-op.
                if (pend_q) begin
                    pend_d = 1'b0;
                    done_d = 1'b0;
                    if (op_q != OP_NONE) begin
                        state_d    = ST_CMD;
                        cnt_d      = 6'd8;
                        cs_rom_n_d = (op_q != OP_ROM_RD);
                        cs_ram_n_d = (op_q == OP_ROM_RD);
                    end
                end else if (!done_q) begin
                    done_d = 1'b1;
                end else if (spi_executing) begin
                    pend_d = 1'b1;
                    op_d   = req_op;
                    case (req_op)
                        OP_ROM_RD: tx_d = {ROM_CMD, ROM_HI, rom_addr, 8'h00};
                        OP_RAM_RD: tx_d = {RAM_RD_CMD, ram_addr, 16'h0000};
                        OP_RAM_WR: tx_d = {RAM_WR_CMD, ram_addr, wdata, 8'h00};
                        default:   tx_d = '0;
                    endcase
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (rise && state_q == ST_DATA) rx_d = {rx_q[6:0], miso};
                if (fall) begin
                    tx_d = {tx_q[38:0], 1'b0};
                    if (cnt_q != 6'd1) begin
                        cnt_d = cnt_q - 6'd1;
                    end else begin
                        case (state_q)
                            ST_CMD: begin
                                state_d = ST_ADDR;
                                cnt_d   = (op_q == OP_ROM_RD) ? 6'(ROM_BITS - 16) : 6'(RAM_BITS - 16);
                            end
                            ST_ADDR: begin
                                state_d = ST_DATA;
                                cnt_d   = 6'd8;
                            end
                            default: begin
                                state_d    = ST_FINISH;
                                cs_rom_n_d = 1'b1;
                                cs_ram_n_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_q == OP_ROM_RD || op_q == OP_RAM_RD) rdata_d = rx_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= 8'h00;
            done_q     <= 1'b1;
            cs_rom_n_q <= 1'b1;
            cs_ram_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            cs_rom_n_q <= cs_rom_n_d;
            cs_ram_n_q <= cs_ram_n_d;
        end
    end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- SPI master sitting directly upstream of the control unit. Serves every `spi_executing`/`spi_done` request the CU raises.
- Three request types:
  - ROM byte fetch at PC, from serial flash. Feeds `irin` and ROMO data.
  - RAM byte read, from SPI SRAM.
  - RAM byte write, to SPI SRAM.
- Returns read bytes on `rdata`.
- Signals completion with a rising edge on `spi_done`, which the CU detects as `spi_done && !spi_done_reg`.

Parameters:
- CLK_DIV, 1: system clocks per SCK half-period. Legal range 1..15.
- ROM_HI, 8'h00: upper flash address byte. Flash address = {ROM_HI, rom_addr}.
- ROM_CMD, 8'h03: flash read opcode.
- RAM_RD_CMD, 8'h03: SRAM read opcode.
- RAM_WR_CMD, 8'h02: SRAM write opcode.

Ports:
- clk  in  1  system clock. All logic rises on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_executing  in  1  request strobe from CU, level.
- op_rom_rd  in  1  ROMO flag.
- op_ram_rd  in  1  RAMO flag.
- op_ram_wr  in  1  RAMI flag.
- rom_addr  in  16  PC.
- ram_addr  in  16  RAM address (MAR/highbits concatenation).
- wdata  in  8  bus byte to write.
- spi_done  out  1  high = idle/complete; low = transaction in flight.
- rdata  out  8  last byte read.
- sck  out  1  SPI clock, mode 0.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- cs_rom_n  out  1  flash chip select.
- cs_ram_n  out  1  SRAM chip select.

Behaviour:
- Reset (async, rst_n=0):
  - spi_done=1, rdata=8'h00, sck=0, mosi=0, cs_rom_n=1, cs_ram_n=1, state IDLE.
  - Reset mid-transaction aborts immediately with these values. No partial rdata update.
- States: IDLE, CMD, ADDR, DATA, FINISH.
- Accept:
  - In IDLE, sampling spi_executing=1 with spi_done=1 at edge T latches op, address, wdata and opcode.
  - Priority: op_ram_wr > op_ram_rd > op_rom_rd.
  - At T+1: spi_done=0, selected cs_n=0, state CMD, mosi = opcode bit 7.
- No-op request (executing with no op flag): spi_done=0 for exactly one cycle (T+1), high at T+2. No chip select, rdata unchanged.
- While spi_done=0, spi_executing is ignored.
- Bit timing, mode 0 (CPOL=0, CPHA=0):
  - SCK low half then high half, each CLK_DIV cycles.
  - mosi changes only while sck low. miso sampled on the clk edge where sck rises.
  - All fields are MSB first.
- Frame length N:
  - ROM read: 8 cmd + 24 addr + 8 data = 40 bits.
  - RAM read/write: 8 cmd + 16 addr + 8 data = 32 bits.
  - 6-bit bit counter, reloaded per field. CMD→ADDR→DATA on field exhaustion.
- DATA phase:
  - Read: shift miso into an internal register, mosi=0.
  - Write: shift wdata out. The miso value is discarded.
- FINISH (one cycle after the last sck falling half):
  - sck=0, cs_n=1.
  - Read: rdata loaded with the shifted byte.
  - spi_done=1 on the next edge, together with the rdata update.
- Latency: spi_done rises exactly 2*CLK_DIV*N + 2 cycles after accept edge T.
  - CLK_DIV=1: ROM = 82 cycles, RAM = 66 cycles.
- rdata holds its value until the next completed read. Writes never alter rdata.
- Back-to-back: a new request may be accepted on the first edge where spi_done=1 is sampled, so there are zero idle cycles required. cs_n is guaranteed high for at least one clk between frames.
- Input changes (op, addresses, wdata) after accept have no effect on the frame.

Decomposition:
- Package spi_mem_pkg holds:
  - state enum spi_state_t.
  - op enum spi_op_t (OP_NONE, OP_ROM_RD, OP_RAM_RD, OP_RAM_WR).
  - frame-length constants ROM_BITS=40, RAM_BITS=32.
  - opcode defaults.
- Sub-module spi_sck_gen: CLK_DIV counter producing sck plus one-cycle `rise`/`fall` enables, cleared when idle.
- The FSM and shift registers stay in spi_mem_ctrl.

Test Plan:
- ROM fetch:
  - Stimulus: CLK_DIV=1, op_rom_rd=1, rom_addr=16'h1234; flash model returns 8'hA5.
  - Required response: mosi stream 03 00 12 34; cs_rom_n low 80 cycles; spi_done rises at T+82; rdata=8'hA5; cs_ram_n stays 1.
- RAM write:
  - Stimulus: op_ram_wr=1, ram_addr=16'h00FF, wdata=8'h3C.
  - Required response: mosi 02 00 FF 3C on cs_ram_n; spi_done rises at T+66; rdata unchanged.
- Priority and read:
  - Stimulus: op_ram_rd=1 and op_rom_rd=1, ram_addr=16'hBEEF; SRAM returns 8'h5A.
  - Required response: only cs_ram_n asserted; mosi 03 BE EF; rdata=8'h5A.
- No-op:
  - Stimulus: spi_executing=1 with all op flags 0.
  - Required response: spi_done low exactly one cycle; no cs activity; rdata unchanged.
- Async reset mid-frame:
  - Stimulus: rst_n pulsed low during the ADDR phase.
  - Required response: cs_*_n=1, sck=0, spi_done=1 immediately; next request completes normally.
- CLK_DIV=3 with CU in the loop:
  - Stimulus: fetch-execute of a load instruction.
  - Required response: sck half-period 3 cycles; ROM latency 242 cycles; CU advances UPDATE_SPI→UPDATE_IR exactly one cycle after spi_done rises.
